// File: rtl/or_tree_pipe.sv
// Pipelined 4-ary OR-reduction tree with a valid chain; one register stage per tree level.
// Optional sticky accumulator and saturating hit counter enabled by defining OR_TREE_STICKY_EN.

module or_tree_pipe_or4 #(
  parameter PROP = "DEFAULT"
) (
  input  logic [3:0] a,
  output logic       y
);

  // PROP is carried down to the leaf so the implementation flow can key cell choice off it.
  if (PROP == "DEFAULT") begin : g_default
    assign y = |a;
  end else begin : g_prop
    assign y = |a;
  end

endmodule

module or_tree_pipe #(
  parameter int N    = 16,
  parameter     PROP = "DEFAULT"
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         in_valid,
  input  logic [N-1:0] in,
  input  logic         clear,
  output logic         out_valid,
  output logic         z,
  output logic         z_sticky,
  output logic [7:0]   hit_cnt
);

  function automatic int lvl_width(input int n, input int k);
    int w;
    w = n;
    for (int i = 0; i < k; i++) begin
      w = (w + 32'd3) / 32'd4;
    end
    return w;
  endfunction

  function automatic int tree_depth(input int n);
    int w;
    int d;
    w = (n + 32'd3) / 32'd4;
    d = 32'd1;
    for (int i = 0; i < 8; i++) begin
      if (w > 32'd1) begin
        w = (w + 32'd3) / 32'd4;
        d = d + 32'd1;
      end
    end
    return d;
  endfunction

  // Bit offset of level k inside the flattened tree bus (level 0 is the raw input).
  function automatic int lvl_offset(input int n, input int k);
    int off;
    off = 32'd0;
    for (int i = 0; i < k; i++) begin
      off = off + lvl_width(n, i);
    end
    return off;
  endfunction

  localparam int D     = tree_depth(N);
  localparam int TOTAL = lvl_offset(N, D + 1);

  wire  [TOTAL-1:0] tree_s;
  logic [D-1:0]     vld_r;
  logic [D:0]       vld_s;

  assign tree_s[N-1:0] = in;
  assign vld_s         = {vld_r, in_valid};

  // Valid chain: bit k-1 marks that level k holds a fresh result.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      vld_r <= {D{1'b0}};
    end else begin
      vld_r <= vld_s[D-1:0];
    end
  end

  for (genvar k = 1; k <= D; k++) begin : g_lvl
    localparam int W_PREV   = lvl_width(N, k - 1);
    localparam int W_CUR    = lvl_width(N, k);
    localparam int OFF_PREV = lvl_offset(N, k - 1);
    localparam int OFF_CUR  = lvl_offset(N, k);

    logic [4*W_CUR-1:0] pad_s;
    logic [W_CUR-1:0]   or_s;
    logic [W_CUR-1:0]   data_r;

    // Zero-pad the previous level up to a whole number of 4-input groups.
    always_comb begin
      pad_s             = {(4*W_CUR){1'b0}};
      pad_s[W_PREV-1:0] = tree_s[OFF_PREV +: W_PREV];
    end

    for (genvar j = 0; j < W_CUR; j++) begin : g_gate
      or_tree_pipe_or4 #(.PROP(PROP)) u_or4 (
        .a (pad_s[4*j +: 4]),
        .y (or_s[j])
      );
    end

    // Level register loads only alongside a valid token, so the last level holds z between results.
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        data_r <= {W_CUR{1'b0}};
      end else if (vld_s[k-1]) begin
        data_r <= or_s;
      end else begin
        data_r <= data_r;
      end
    end

    assign tree_s[OFF_CUR +: W_CUR] = data_r;
  end

  assign out_valid = vld_s[D];
  assign z         = tree_s[TOTAL-1];

`ifdef OR_TREE_STICKY_EN
  logic       hit_s;
  logic [7:0] cnt_base_s;
  logic [7:0] hit_cnt_nxt_s;
  logic       z_sticky_r;
  logic [7:0] hit_cnt_r;

  assign hit_s = out_valid & z;

  // Clear zeroes the base first so a hit in the same cycle still counts.
  always_comb begin
    if (clear) begin
      cnt_base_s = 8'd0;
    end else begin
      cnt_base_s = hit_cnt_r;
    end
    if (hit_s && (cnt_base_s != 8'd255)) begin
      hit_cnt_nxt_s = cnt_base_s + 8'd1;
    end else begin
      hit_cnt_nxt_s = cnt_base_s;
    end
  end

  // Sticky flag and hit counter.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      z_sticky_r <= 1'b0;
      hit_cnt_r  <= 8'd0;
    end else begin
      z_sticky_r <= (z_sticky_r & ~clear) | hit_s;
      hit_cnt_r  <= hit_cnt_nxt_s;
    end
  end

  assign z_sticky = z_sticky_r;
  assign hit_cnt  = hit_cnt_r;
`else
  logic unused_clear_s;

  assign unused_clear_s = clear;
  assign z_sticky       = 1'b0;
  assign hit_cnt        = 8'd0;
`endif

endmodule

// File: tb/tb_or_tree_pipe.sv
// Randomized self-checking bench for or_tree_pipe: N=16 (depth 2) and N=17 (depth 3) side by side,
// compared against a due-time queue model; sticky expectations apply when OR_TREE_STICKY_EN is defined.

module tb_or_tree_pipe;

  logic        clk = 1'b0;
  logic        nreset;
  logic        clear;
  logic        v16, v17;
  logic [15:0] d16;
  logic [16:0] d17;
  logic        ov16, z16, zs16;
  logic        ov17, z17, zs17;
  logic [7:0]  hc16, hc17;

  always #5 clk = ~clk;

  or_tree_pipe #(.N(16)) u_dut16 (
    .clk(clk), .nreset(nreset), .in_valid(v16), .in(d16), .clear(clear),
    .out_valid(ov16), .z(z16), .z_sticky(zs16), .hit_cnt(hc16)
  );

  or_tree_pipe #(.N(17)) u_dut17 (
    .clk(clk), .nreset(nreset), .in_valid(v17), .in(d17), .clear(clear),
    .out_valid(ov17), .z(z17), .z_sticky(zs17), .hit_cnt(hc17)
  );

  typedef struct {
    int   due;
    logic zv;
  } exp_t;

  int   edge_cnt = 0;
  int   n_vec    = 0;
  int   n_err    = 0;
  exp_t q[2][$];
  logic last_z[2];
  int   st[2];
  int   cnt[2];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      q[i].delete();
      last_z[i] = 1'b0;
      st[i]     = 0;
      cnt[i]    = 0;
    end
  endtask

  // Compare one DUT against the model for the current cycle, then advance the sticky model.
  task automatic check_dut(input int i, input logic ov, input logic zz, input logic zs,
                           input logic [7:0] hc, input logic clr);
    logic  e_ov;
    logic  hit;
    string sfx;
    sfx  = (i == 0) ? "_n16" : "_n17";
    e_ov = (q[i].size() > 0) && (q[i][0].due == edge_cnt);
    if (e_ov) begin
      last_z[i] = q[i][0].zv;
      void'(q[i].pop_front());
    end
    chk({"out_valid", sfx}, {31'd0, ov}, {31'd0, e_ov});
    chk({"z", sfx}, {31'd0, zz}, {31'd0, last_z[i]});
`ifdef OR_TREE_STICKY_EN
    chk({"z_sticky", sfx}, {31'd0, zs}, st[i]);
    chk({"hit_cnt", sfx}, {24'd0, hc}, cnt[i]);
`else
    chk({"z_sticky", sfx}, {31'd0, zs}, 32'd0);
    chk({"hit_cnt", sfx}, {24'd0, hc}, 32'd0);
`endif
    hit    = e_ov & last_z[i];
    st[i]  = (clr ? 0 : st[i]) | int'(hit);
    cnt[i] = clr ? 0 : cnt[i];
    if (hit && cnt[i] < 255) cnt[i]++;
  endtask

  task automatic step(input logic a16, input logic [15:0] b16,
                      input logic a17, input logic [16:0] b17, input logic clr);
    @(negedge clk);
    check_dut(0, ov16, z16, zs16, hc16, clr);
    check_dut(1, ov17, z17, zs17, hc17, clr);
    v16 = a16; d16 = b16; v17 = a17; d17 = b17; clear = clr;
    if (a16) q[0].push_back(exp_t'{due: edge_cnt + 2, zv: |b16});
    if (a17) q[1].push_back(exp_t'{due: edge_cnt + 3, zv: |b17});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 17'h0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ov16"}, {31'd0, ov16}, 32'd0);
    chk({tag, "_z16"},  {31'd0, z16},  32'd0);
    chk({tag, "_zs16"}, {31'd0, zs16}, 32'd0);
    chk({tag, "_hc16"}, {24'd0, hc16}, 32'd0);
    chk({tag, "_ov17"}, {31'd0, ov17}, 32'd0);
    chk({tag, "_z17"},  {31'd0, z17},  32'd0);
    chk({tag, "_zs17"}, {31'd0, zs17}, 32'd0);
    chk({tag, "_hc17"}, {24'd0, hc17}, 32'd0);
  endtask

  // Asynchronous reset pulse lasting one cycle; in-flight results must vanish.
  task automatic pulse_reset();
    @(negedge clk);
    nreset = 1'b0;
    v16 = 1'b0; v17 = 1'b0; clear = 1'b0;
    #1;
    model_reset();
    check_zero("mid_reset");
    @(negedge clk);
    nreset = 1'b1;
  endtask

  function automatic logic [16:0] rnd_vec(input int w);
    logic [16:0] v;
    v = 17'h0;
    case ($urandom_range(0, 3))
      0:       v = 17'h0;
      1:       v[$urandom_range(0, w - 1)] = 1'b1;
      default: v = 17'($urandom);
    endcase
    if (w == 16) v[16] = 1'b0;
    return v;
  endfunction

  initial begin
    logic [16:0] r16;
    logic [16:0] r17;
    nreset = 1'b0; clear = 1'b0;
    v16 = 1'b0; v17 = 1'b0; d16 = 16'h0; d17 = 17'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    nreset = 1'b1;

    // Single input, then hold of z.
    step(1'b1, 16'h0400, 1'b1, 17'h00400, 1'b0);
    idle(5);

    // Back-to-back inputs after a clear.
    step(1'b0, 16'h0, 1'b0, 17'h0, 1'b1);
    step(1'b1, 16'h0000, 1'b1, 17'h00000, 1'b0);
    step(1'b1, 16'h8000, 1'b1, 17'h08000, 1'b0);
    step(1'b1, 16'h0000, 1'b1, 17'h00000, 1'b0);
    step(1'b1, 16'h0001, 1'b1, 17'h00001, 1'b0);
    idle(5);

    // Only the padded-group bit of N=17, then zero.
    step(1'b0, 16'h0, 1'b1, 17'h10000, 1'b0);
    step(1'b0, 16'h0, 1'b1, 17'h00000, 1'b0);
    idle(5);

    // Clear coinciding with a hit, then clear with no hit.
    step(1'b1, 16'h0001, 1'b1, 17'h00001, 1'b0);
    step(1'b0, 16'h0, 1'b0, 17'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 17'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 17'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 17'h0, 1'b1);
    idle(4);

    // Random traffic with gaps and occasional clears.
    for (int i = 0; i < 600; i++) begin
      r16 = rnd_vec(16);
      r17 = rnd_vec(17);
      step(($urandom_range(0, 9) < 7), r16[15:0], ($urandom_range(0, 9) < 6), r17,
           ($urandom_range(0, 19) == 0));
    end
    idle(4);

    // Saturation of the hit counter, then clear.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 16'($urandom) | 16'h0001, 1'b1, 17'($urandom) | 17'h10000, 1'b0);
    end
    idle(5);
    step(1'b0, 16'h0, 1'b0, 17'h0, 1'b1);
    idle(4);

    // Reset one cycle after a nonzero input.
    step(1'b1, 16'h00f0, 1'b1, 17'h10000, 1'b0);
    pulse_reset();
    idle(6);

    // Traffic resumes cleanly after reset.
    for (int i = 0; i < 100; i++) begin
      r16 = rnd_vec(16);
      r17 = rnd_vec(17);
      step($urandom_range(0, 1) == 1, r16[15:0], $urandom_range(0, 1) == 1, r17,
           ($urandom_range(0, 15) == 0));
    end
    idle(6);
    chk("drain_n16", q[0].size(), 32'd0);
    chk("drain_n17", q[1].size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
